// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multi-cycle CPU sequencing controller.
// Opcode field values and the decoded-instruction record live here.
package mc_pkg;

  localparam int OP_W    = 10;
  localparam int ALUOP_W = 4;
  localparam int JUMP_W  = 3;

  localparam logic [JUMP_W-1:0] JUMP_NONE = 3'd6;

  // op[8:5] values within the op[9]=1, op[8]=1 load/store group
  localparam logic [3:0] OPF_LOADI = 4'b1000;
  localparam logic [3:0] OPF_LOAD  = 4'b1001;
  localparam logic [3:0] OPF_STORE = 4'b1010;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_e;

  typedef enum logic [2:0] {
    CL_NOP,
    CL_ALU,
    CL_ALUCMP,
    CL_LOADI,
    CL_LOAD,
    CL_STORE,
    CL_JUMP,
    CL_ILLEGAL
  } cls_e;

  typedef struct packed {
    cls_e               cls;
    logic [ALUOP_W-1:0] aluop;
    logic               alu_src;
    logic [JUMP_W-1:0]  jump;
    logic               ls;
  } dec_t;

  localparam dec_t DEC_NOP = '{
    cls:     CL_NOP,
    aluop:   '0,
    alu_src: 1'b0,
    jump:    JUMP_NONE,
    ls:      1'b0
  };

endpackage

// File: rtl/multicycle_control_op_classify.sv
// Combinational opcode decoder: instruction class plus the ALU/jump/LS fields
// of the single-cycle encoding. Latched by the sequencer in DECODE.
module op_classify
  import mc_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output dec_t            dec
);

  always_comb begin
    dec = DEC_NOP;
    if (op == '0) begin
      dec.cls = CL_NOP;
    end else if (!op[9]) begin
      // op[4:2] = 101 is the compare group: flags only, no register write
      dec.cls     = (op[4:2] == 3'b101) ? CL_ALUCMP : CL_ALU;
      dec.alu_src = op[3];
      if (!op[4])                dec.aluop = op[3:0];
      else if (op[3:0] == 4'd0)  dec.aluop = 4'd7;
      else                       dec.aluop = 4'd3;
    end else if (!op[8]) begin
      dec.cls  = CL_JUMP;
      dec.jump = op[7:5];
    end else begin
      unique case (op[8:5])
        OPF_LOADI: begin
          dec.cls   = CL_LOADI;
          dec.aluop = 4'd6;
          dec.ls    = 1'b1;
        end
        OPF_LOAD: begin
          dec.cls = CL_LOAD;
          dec.ls  = 1'b1;
        end
        OPF_STORE: begin
          dec.cls = CL_STORE;
          dec.ls  = 1'b1;
        end
        default: dec.cls = CL_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared memory port,
// with a request timeout that raises bus_error and restarts at FETCH.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_jump,
  output logic [JUMP_W-1:0]  jump,
  output logic               alu_src,
  output logic [ALUOP_W-1:0] aluop,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               ls,
  output logic               illegal,
  output logic               bus_error
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_e            state_q, state_d;
  dec_t              dec_q, dec_d;
  dec_t              dec_now;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              timeout;

  op_classify u_cls (
    .op  (op),
    .dec (dec_now)
  );

  assign timeout = (cnt_q == WAIT_W'(MAX_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      dec_q   <= DEC_NOP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dec_d      = dec_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_jump    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    bus_error  = 1'b0;
    alu_src    = 1'b0;
    aluop      = '0;
    jump       = JUMP_NONE;
    ls         = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        // Timeout cycle: request withdrawn, re-enter FETCH at the same PC
        mem_req   = !timeout;
        bus_error = timeout;
        if (!timeout && mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        illegal = (dec_now.cls == CL_ILLEGAL);
        dec_d   = illegal ? DEC_NOP : dec_now;
        state_d = (dec_now.cls == CL_NOP || illegal) ? ST_FETCH : ST_EXEC;
      end
      ST_EXEC: begin
        unique case (dec_q.cls)
          CL_ALU, CL_LOADI:   state_d = ST_WB;
          CL_LOAD, CL_STORE:  state_d = ST_MEM;
          CL_JUMP: begin
            pc_jump = 1'b1;
            state_d = ST_FETCH;
          end
          default:            state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        iord      = 1'b1;
        mem_req   = !timeout;
        bus_error = timeout;
        mem_we    = !timeout && (dec_q.cls == CL_STORE);
        if (timeout)        state_d = ST_FETCH;
        else if (mem_ready) state_d = (dec_q.cls == CL_LOAD) ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (dec_q.cls == CL_LOAD);
        state_d    = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
      alu_src = dec_q.alu_src;
      aluop   = dec_q.aluop;
      jump    = dec_q.jump;
      ls      = dec_q.ls;
    end

    // Any ready, idle or timeout cycle restarts the count
    cnt_d = (mem_req && !mem_ready) ? cnt_q + WAIT_W'(1) : '0;

    if (rst) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_jump    = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
      bus_error  = 1'b0;
      alu_src    = 1'b0;
      aluop      = '0;
      jump       = JUMP_NONE;
      ls         = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction transaction model
// predicts latency, pulse counts and held datapath fields.
module tb_multicycle_control;
  import mc_pkg::*;

  logic         clk, rst;
  logic [9:0]   op;
  logic         mem_ready;
  logic         mem_req, mem_we, iord, ir_write, pc_write, pc_jump;
  logic [2:0]   jump;
  logic         alu_src;
  logic [3:0]   aluop;
  logic         reg_write, mem_to_reg, ls, illegal, bus_error;

  int n_chk, n_fail;

  multicycle_control dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_jump    (pc_jump),
    .jump       (jump),
    .alu_src    (alu_src),
    .aluop      (aluop),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .ls         (ls),
    .illegal    (illegal),
    .bus_error  (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int R_NOP = 0, R_ALU = 1, R_CMP = 2, R_LDI = 3,
                 R_LD  = 4, R_ST  = 5, R_JMP = 6, R_ILL = 7;

  typedef struct {
    int cls, aluop, alu_src, jump, ls, base, wr, mem;
  } ref_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Instruction semantics straight from the opcode table, in plain arithmetic
  function automatic ref_t ref_dec(input logic [9:0] o);
    ref_t r;
    int v, hi5, lo4;
    v   = int'(o);
    hi5 = v / 32;
    lo4 = v % 16;
    r = '{cls: R_NOP, aluop: 0, alu_src: 0, jump: 6, ls: 0, base: 2, wr: 0, mem: 0};
    if (v == 0) begin
      r.cls = R_NOP;
    end else if (v < 512) begin
      r.alu_src = (v / 8) % 2;
      r.aluop   = ((v / 16) % 2 == 0) ? lo4 : (lo4 == 0 ? 7 : 3);
      if ((v / 4) % 8 == 5) begin r.cls = R_CMP; r.base = 3; end
      else begin r.cls = R_ALU; r.base = 4; r.wr = 1; end
    end else if (v < 768) begin
      r.cls = R_JMP; r.jump = hi5 % 8; r.base = 3;
    end else if (hi5 == 24) begin
      r.cls = R_LDI; r.aluop = 6; r.ls = 1; r.base = 4; r.wr = 1;
    end else if (hi5 == 25) begin
      r.cls = R_LD; r.ls = 1; r.base = 5; r.wr = 1; r.mem = 1;
    end else if (hi5 == 26) begin
      r.cls = R_ST; r.ls = 1; r.base = 4; r.mem = 1;
    end else begin
      r.cls = R_ILL;
    end
    return r;
  endfunction

  task automatic chk_idle(input string p);
    chk({p, "_mem_req"}, mem_req, 0);
    chk({p, "_mem_we"}, mem_we, 0);
    chk({p, "_iord"}, iord, 0);
    chk({p, "_ir_write"}, ir_write, 0);
    chk({p, "_pc_write"}, pc_write, 0);
    chk({p, "_pc_jump"}, pc_jump, 0);
    chk({p, "_reg_write"}, reg_write, 0);
    chk({p, "_mem_to_reg"}, mem_to_reg, 0);
    chk({p, "_ls"}, ls, 0);
    chk({p, "_alu_src"}, alu_src, 0);
    chk({p, "_illegal"}, illegal, 0);
    chk({p, "_bus_error"}, bus_error, 0);
    chk({p, "_aluop"}, aluop, 0);
    chk({p, "_jump"}, jump, 6);
  endtask

  // Runs one instruction from the negedge of its first FETCH cycle; wf/wm are
  // wait states for fetch and memory phases (wm >= 15 never answers).
  task automatic run_instr(input logic [9:0] iop, input int wf, input int wm, input string nm);
    ref_t r;
    int to, len, fcnt, mcnt;
    int n_ir, n_pcw, n_rw, n_m2r, n_pcj, n_pcj_ex, n_ill, n_ill_dc, n_req, n_rio, n_we, n_be;
    r = ref_dec(iop);
    to = (r.mem != 0 && wm >= 15) ? 1 : 0;
    len = to ? wf + 19 : r.base + wf + (r.mem != 0 ? wm : 0);
    {fcnt, mcnt, n_ir, n_pcw, n_rw, n_m2r, n_pcj, n_pcj_ex} = '0;
    {n_ill, n_ill_dc, n_req, n_rio, n_we, n_be} = '0;
    op = iop;
    for (int k = 0; k < len; k++) begin
      if (k > wf + 1) op = 10'($urandom);
      if (mem_req && !iord) begin
        mem_ready = (fcnt >= wf);
        fcnt++;
      end else if (mem_req) begin
        mem_ready = !to && (mcnt >= wm);
        mcnt++;
      end else begin
        mem_ready = 1'($urandom);
      end
      #1;
      if (ir_write) n_ir++;
      if (pc_write) n_pcw++;
      if (reg_write) begin
        n_rw++;
        if (mem_to_reg) n_m2r++;
        chk({nm, "_wb_aluop"}, aluop, r.aluop);
        chk({nm, "_wb_ls"}, ls, r.ls);
      end
      if (pc_jump) begin n_pcj++; if (k == wf + 2) n_pcj_ex++; end
      if (illegal) begin n_ill++; if (k == wf + 1) n_ill_dc++; end
      if (mem_req) n_req++;
      if (mem_req && iord) n_rio++;
      if (mem_we) n_we++;
      if (bus_error) n_be++;
      if (k == wf + 2 && r.cls != R_NOP && r.cls != R_ILL) begin
        chk({nm, "_ex_aluop"}, aluop, r.aluop);
        chk({nm, "_ex_alu_src"}, alu_src, r.alu_src);
        chk({nm, "_ex_jump"}, jump, r.jump);
        chk({nm, "_ex_ls"}, ls, r.ls);
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk({nm, "_end_req"}, mem_req, 1);
    chk({nm, "_end_iord"}, iord, 0);
    chk({nm, "_ir_write"}, n_ir, 1);
    chk({nm, "_pc_write"}, n_pcw, 1);
    chk({nm, "_reg_write"}, n_rw, (r.wr != 0 && !to) ? 1 : 0);
    chk({nm, "_mem_to_reg"}, n_m2r, (r.cls == R_LD && !to) ? 1 : 0);
    chk({nm, "_pc_jump"}, n_pcj, r.cls == R_JMP ? 1 : 0);
    chk({nm, "_pc_jump_exec"}, n_pcj_ex, r.cls == R_JMP ? 1 : 0);
    chk({nm, "_illegal"}, n_ill, r.cls == R_ILL ? 1 : 0);
    chk({nm, "_illegal_dec"}, n_ill_dc, r.cls == R_ILL ? 1 : 0);
    chk({nm, "_req_cycles"}, n_req, wf + 1 + (r.mem != 0 ? (to ? 15 : wm + 1) : 0));
    chk({nm, "_req_iord"}, n_rio, r.mem != 0 ? (to ? 15 : wm + 1) : 0);
    chk({nm, "_we_cycles"}, n_we, r.cls == R_ST ? (to ? 15 : wm + 1) : 0);
    chk({nm, "_bus_error"}, n_be, to);
  endtask

  task automatic fetch_timeout();
    int n_req, n_pcw, n_ir, n_be;
    {n_req, n_pcw, n_ir, n_be} = '0;
    op = 10'($urandom);
    for (int k = 0; k < 16; k++) begin
      mem_ready = (k == 15);  // ready on the timeout cycle must be ignored
      #1;
      if (mem_req) n_req++;
      if (pc_write) n_pcw++;
      if (ir_write) n_ir++;
      if (bus_error) n_be++;
      if (k == 15) begin
        chk("fto_bus_error_cycle", bus_error, 1);
        chk("fto_req_drop", mem_req, 0);
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("fto_req_cycles", n_req, 15);
    chk("fto_pc_write", n_pcw, 0);
    chk("fto_ir_write", n_ir, 0);
    chk("fto_bus_error", n_be, 1);
    chk("fto_refetch_req", mem_req, 1);
    chk("fto_refetch_iord", iord, 0);
  endtask

  initial begin
    int wf, wm, sel;
    logic [9:0] rop;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    op = '0;
    mem_ready = 1'b0;
    #2;
    chk_idle("rst0");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel0_req", mem_req, 1);
    chk("rel0_iord", iord, 0);
    @(negedge clk);

    run_instr(10'h00A, 0, 0, "alu_0a");
    run_instr(10'b1100100000, 0, 3, "load_w3");
    run_instr(10'b1001100000, 0, 0, "jump_3");
    run_instr(10'b1111100000, 1, 0, "illegal");
    run_instr(10'b0000010100, 0, 0, "cmp");
    run_instr(10'b1101000000, 2, 1, "store");
    run_instr(10'b1100000101, 0, 0, "loadi");
    run_instr(10'h000, 0, 0, "nop");
    run_instr(10'h018, 0, 0, "alu_imm7");
    run_instr(10'b1100111111, 1, 99, "load_to");
    run_instr(10'b1101000011, 0, 99, "store_to");
    fetch_timeout();
    run_instr(10'h013, 14, 0, "alu_f14");

    // Asynchronous reset in the middle of a STORE memory phase
    op = 10'b1101000000;
    mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("pre_rst_req", mem_req, 1);
    chk("pre_rst_we", mem_we, 1);
    rst = 1'b1;
    #1;
    chk_idle("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_req", mem_req, 1);
    chk("rel_iord", iord, 0);
    chk("rel_ir_write", ir_write, 0);

    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 7);
      rop = 10'($urandom);
      case (sel)
        0: rop = '0;
        1: rop[9] = 1'b0;
        2: rop[9:5] = 5'b11000;
        3: rop[9:5] = 5'b11001;
        4: rop[9:5] = 5'b11010;
        5: rop[9:8] = 2'b10;
        6: rop[9:8] = 2'b11;
        default: ;
      endcase
      wf = $urandom_range(0, 4);
      wm = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
      run_instr(rop, wf, wm, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
